// File: rtl/spi_controller_if.sv
// Core-side register bus for spi_controller: select/strobe, address, write data with lane inhibit, read data.
interface spi_controller_if;
  logic [1:0]  address;
  logic [31:0] data_in;
  logic [3:0]  write_mask;
  logic [31:0] data_out;
  logic        bus_enable;
  logic        write_enable;

  modport master (
    output address, data_in, write_mask, bus_enable, write_enable,
    input  data_out
  );

  modport slave (
    input  address, data_in, write_mask, bus_enable, write_enable,
    output data_out
  );
endinterface

// File: rtl/spi_controller.sv
// Memory-mapped SPI master, mode 0, 8-bit MSB first, with DATA/CONTROL/STATUS registers.
// Every DATA write that is accepted sends one byte on MOSI and captures one byte from MISO.
module spi_controller #(
  parameter int unsigned DEFAULT_DIVIDER = 3
) (
  input  logic             clk,
  input  logic             reset,
  spi_controller_if.slave  bus,
  output logic             spi_clk,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             spi_cs_n
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BIT_W  = 3;
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_CONTROL = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;

  typedef enum logic [1:0] {IDLE, CLK_LO, CLK_HI} state_e;

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   counter_q, counter_d;
  logic [BIT_W-1:0]    bit_count_q, bit_count_d;
  logic [BYTE_W-1:0]   tx_shift_q, tx_shift_d;
  logic [BYTE_W-1:0]   rx_shift_q, rx_shift_d;
  logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
  logic [BYTE_W-1:0]   divider_q, divider_d;
  logic                rx_valid_q, rx_valid_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;
  logic                cs_assert_q, cs_assert_d;
  logic                spi_clk_q, spi_clk_d;
  logic                spi_mosi_q, spi_mosi_d;
  logic                spi_cs_n_q, spi_cs_n_d;

  logic wr_stb_c, rd_stb_c, data_wr_c;
  logic unused_bits_c;

  assign wr_stb_c  = bus.bus_enable & bus.write_enable;
  assign rd_stb_c  = bus.bus_enable & ~bus.write_enable;
  assign data_wr_c = wr_stb_c & (bus.address == ADDR_DATA) & ~bus.write_mask[0];
  assign unused_bits_c = ^{bus.data_in[31:9], bus.write_mask[3:2]};

  // Register updates and the bit-serial state machine.
  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    bit_count_d = bit_count_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    divider_d   = divider_q;
    rx_valid_d  = rx_valid_q;
    busy_d      = busy_q;
    overrun_d   = overrun_q;
    cs_assert_d = cs_assert_q;
    spi_clk_d   = spi_clk_q;
    spi_mosi_d  = spi_mosi_q;

    if (wr_stb_c && bus.address == ADDR_CONTROL && !busy_q) begin
      if (!bus.write_mask[0]) divider_d   = bus.data_in[7:0];
      if (!bus.write_mask[1]) cs_assert_d = bus.data_in[8];
    end
    if (wr_stb_c && bus.address == ADDR_STATUS) overrun_d = 1'b0;
    if (data_wr_c && busy_q) overrun_d = 1'b1;
    if (rd_stb_c && bus.address == ADDR_DATA) rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        spi_clk_d = 1'b0;
        if (data_wr_c && !busy_q) begin
          tx_shift_d  = bus.data_in[7:0];
          spi_mosi_d  = bus.data_in[7];
          counter_d   = divider_q;
          bit_count_d = '0;
          busy_d      = 1'b1;
          state_d     = CLK_LO;
        end
      end
      CLK_LO: begin
        if (counter_q == '0) begin
          spi_clk_d  = 1'b1;
          rx_shift_d = {rx_shift_q[6:0], spi_miso};
          counter_d  = divider_q;
          state_d    = CLK_HI;
        end else begin
          counter_d = counter_q - BYTE_W'(1);
        end
      end
      CLK_HI: begin
        if (counter_q == '0) begin
          spi_clk_d = 1'b0;
          // Completion overrides a same-cycle DATA read clearing rx_valid.
          if (bit_count_q == BIT_W'(7)) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = IDLE;
          end else begin
            tx_shift_d  = {tx_shift_q[6:0], 1'b0};
            spi_mosi_d  = tx_shift_q[6];
            bit_count_d = bit_count_q + BIT_W'(1);
            counter_d   = divider_q;
            state_d     = CLK_LO;
          end
        end else begin
          counter_d = counter_q - BYTE_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    spi_cs_n_d = ~cs_assert_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      bit_count_q <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      divider_q   <= BYTE_W'(DEFAULT_DIVIDER);
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      cs_assert_q <= 1'b0;
      spi_clk_q   <= 1'b0;
      spi_mosi_q  <= 1'b0;
      spi_cs_n_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      bit_count_q <= bit_count_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      divider_q   <= divider_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      cs_assert_q <= cs_assert_d;
      spi_clk_q   <= spi_clk_d;
      spi_mosi_q  <= spi_mosi_d;
      spi_cs_n_q  <= spi_cs_n_d;
    end
  end

  // Read mux is combinational from address and registered state.
  always_comb begin
    bus.data_out = '0;
    case (bus.address)
      ADDR_DATA:    bus.data_out = {24'b0, rx_data_q};
      ADDR_CONTROL: bus.data_out = {23'b0, cs_assert_q, divider_q};
      ADDR_STATUS:  bus.data_out = {29'b0, overrun_q, rx_valid_q, busy_q};
      default:      bus.data_out = '0;
    endcase
  end

  assign spi_clk  = spi_clk_q;
  assign spi_mosi = spi_mosi_q;
  assign spi_cs_n = spi_cs_n_q;

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: directed bus traffic pushes expectations, one monitor checks
// bus reads, serialised MOSI bytes with their SPI clock high time, and pin states.
module tb_spi_controller;

  logic clk = 1'b0;
  logic reset;
  logic spi_clk, spi_mosi, spi_miso, spi_cs_n;
  logic loopback;
  logic [7:0] miso_byte;
  logic done;

  always #5 clk = ~clk;

  spi_controller_if bus_if ();

  spi_controller #(.DEFAULT_DIVIDER(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_if),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n)
  );

  localparam logic [1:0] A_DATA = 2'd0, A_CTRL = 2'd1, A_STAT = 2'd2, A_RSVD = 2'd3;

  typedef struct { logic [1:0] addr; logic [31:0] data; } rd_exp_t;
  typedef struct { logic [7:0] byte_v; int half; } spi_exp_t;
  typedef struct { logic sclk; logic cs_n; } pin_exp_t;

  rd_exp_t  rd_q[$];
  spi_exp_t spi_q[$];
  pin_exp_t pin_q[$];

  int vectors = 0;
  int miscompares = 0;

  // Serial monitor state; MISO pattern follows the monitor's bit count.
  int         mon_bits = 0;
  int         mon_hi = 0;
  logic       mon_prev = 1'b0;
  logic [7:0] mon_byte = 8'h00;

  assign spi_miso = loopback ? spi_mosi : miso_byte[3'd7 - 3'(mon_bits)];

  always @(negedge clk) begin : monitor
    rd_exp_t  re;
    spi_exp_t se;
    pin_exp_t pe;
    if (reset) begin
      mon_bits = 0;
      mon_hi   = 0;
      mon_prev = 1'b0;
    end else begin
      if (bus_if.bus_enable && !bus_if.write_enable) begin
        vectors++;
        if (rd_q.size() == 0) begin
          miscompares++;
          $display("FAIL rd_unexpected addr=%0d got=%08h", bus_if.address, bus_if.data_out);
        end else begin
          re = rd_q.pop_front();
          if (bus_if.data_out !== re.data || bus_if.address !== re.addr) begin
            miscompares++;
            $display("FAIL rd addr=%0d got=%08h exp=%08h (exp addr %0d)",
                     bus_if.address, bus_if.data_out, re.data, re.addr);
          end
        end
      end
      if (spi_clk && !mon_prev) begin
        mon_byte = {mon_byte[6:0], spi_mosi};
        mon_bits++;
      end
      if (spi_clk) mon_hi++;
      if (!spi_clk && mon_prev && mon_bits == 8) begin
        vectors++;
        if (spi_q.size() == 0) begin
          miscompares++;
          $display("FAIL spi_unexpected got=%02h", mon_byte);
        end else begin
          se = spi_q.pop_front();
          if (mon_byte !== se.byte_v || mon_hi != 8 * se.half) begin
            miscompares++;
            $display("FAIL spi_byte got=%02h hi=%0d exp=%02h hi=%0d",
                     mon_byte, mon_hi, se.byte_v, 8 * se.half);
          end
        end
        mon_bits = 0;
        mon_hi   = 0;
      end
      mon_prev = spi_clk;
    end
    if (pin_q.size() != 0) begin
      pe = pin_q.pop_front();
      vectors++;
      if (spi_clk !== pe.sclk || spi_cs_n !== pe.cs_n) begin
        miscompares++;
        $display("FAIL pins got sclk=%b cs_n=%b exp sclk=%b cs_n=%b",
                 spi_clk, spi_cs_n, pe.sclk, pe.cs_n);
      end
    end
    if (done) begin
      vectors++;
      if (rd_q.size() != 0 || spi_q.size() != 0) begin
        miscompares++;
        $display("FAIL leftover rd=%0d spi=%0d exp 0 0", rd_q.size(), spi_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
    bus_if.address = a;
    bus_if.data_in = d;
    bus_if.write_mask = m;
    bus_if.bus_enable = 1'b1;
    bus_if.write_enable = 1'b1;
    @(posedge clk);
    #1;
    bus_if.bus_enable = 1'b0;
    bus_if.write_enable = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp_v);
    rd_exp_t e;
    e.addr = a;
    e.data = exp_v;
    rd_q.push_back(e);
    bus_if.address = a;
    bus_if.bus_enable = 1'b1;
    bus_if.write_enable = 1'b0;
    @(posedge clk);
    #1;
    bus_if.bus_enable = 1'b0;
  endtask

  task automatic expect_byte(input logic [7:0] b, input int half);
    spi_exp_t e;
    e.byte_v = b;
    e.half = half;
    spi_q.push_back(e);
  endtask

  task automatic expect_pins(input logic sclk, input logic cs_n);
    pin_exp_t e;
    e.sclk = sclk;
    e.cs_n = cs_n;
    pin_q.push_back(e);
  endtask

  initial begin
    done = 1'b0;
    loopback = 1'b1;
    miso_byte = 8'h00;
    bus_if.address = 2'd0;
    bus_if.data_in = 32'h0;
    bus_if.write_mask = 4'hF;
    bus_if.bus_enable = 1'b0;
    bus_if.write_enable = 1'b0;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;

    // Reset state
    expect_pins(1'b0, 1'b1);
    rd(A_STAT, 32'h0);
    rd(A_CTRL, 32'h3);
    rd(A_DATA, 32'h0);
    rd(A_RSVD, 32'h0);

    // Loopback byte, divider 0
    wr(A_CTRL, 32'h100, 4'h0);
    expect_pins(1'b0, 1'b0);
    rd(A_CTRL, 32'h100);
    expect_byte(8'hA5, 1);
    wr(A_DATA, 32'hA5, 4'h0);
    idle(15);
    rd(A_STAT, 32'h1);
    rd(A_STAT, 32'h2);
    rd(A_DATA, 32'hA5);
    rd(A_STAT, 32'h0);

    // Divider 4, MISO drives 0xC3
    loopback = 1'b0;
    miso_byte = 8'hC3;
    wr(A_CTRL, 32'h104, 4'h0);
    rd(A_CTRL, 32'h104);
    expect_byte(8'h3C, 5);
    wr(A_DATA, 32'h3C, 4'h0);
    expect_pins(1'b0, 1'b0);
    idle(79);
    rd(A_STAT, 32'h1);
    rd(A_STAT, 32'h2);
    rd(A_DATA, 32'hC3);

    // Overrun: second DATA write while busy is dropped
    loopback = 1'b1;
    wr(A_CTRL, 32'h100, 4'h0);
    expect_byte(8'h11, 1);
    wr(A_DATA, 32'h11, 4'h0);
    wr(A_DATA, 32'h22, 4'h0);
    rd(A_STAT, 32'h5);
    idle(13);
    rd(A_STAT, 32'h5);
    rd(A_STAT, 32'h6);
    wr(A_STAT, 32'h0, 4'h0);
    rd(A_STAT, 32'h2);
    rd(A_DATA, 32'h11);
    rd(A_STAT, 32'h0);

    // Lane masks
    wr(A_DATA, 32'h77, 4'b0001);
    idle(3);
    rd(A_STAT, 32'h0);
    wr(A_CTRL, 32'h0, 4'h0);
    rd(A_CTRL, 32'h0);
    wr(A_CTRL, 32'hFF07, 4'b1101);
    rd(A_CTRL, 32'h100);
    expect_pins(1'b0, 1'b0);

    // DATA read on the completion edge
    expect_byte(8'h5A, 1);
    wr(A_DATA, 32'h5A, 4'h0);
    idle(15);
    rd(A_DATA, 32'h11);
    rd(A_STAT, 32'h2);
    rd(A_DATA, 32'h5A);
    rd(A_STAT, 32'h0);

    // Reset mid-transfer
    wr(A_CTRL, 32'h104, 4'h0);
    wr(A_DATA, 32'hFF, 4'h0);
    idle(20);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    expect_pins(1'b0, 1'b1);
    rd(A_STAT, 32'h0);
    rd(A_CTRL, 32'h3);
    rd(A_DATA, 32'h0);
    idle(40);
    done = 1'b1;
    idle(2);
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
